// File: rtl/cache_pmem_arbiter_if.sv
// Cache/memory bus bundle for cache_pmem_arbiter.
// The arbiter takes the slave view; the caches plus memory side takes the master view.
interface cache_pmem_arbiter_if;
  // I-cache side
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  // D-cache side
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  // Physical memory side
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_pmem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one 4x64-bit burst memory port.
// Define ARB_ROUND_ROBIN_EN for alternating conflict arbitration; otherwise the D-cache wins.
module cache_pmem_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  cache_pmem_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

  state_t       state_q;
  logic [1:0]   k_q;
  logic [255:0] line_q;

  logic         d_req;
  logic         any_req;
  logic         grant_d;
  logic [1:0]   k_next;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {GNT_I, GNT_D} gnt_t;
  gnt_t         last_grant_q;
`endif

  always_comb begin
    d_req   = bus.d_read | bus.d_write;
    any_req = d_req | bus.i_read;
    k_next  = k_q + 2'd1;
`ifdef ARB_ROUND_ROBIN_EN
    // On conflict the port that did not win last time is served.
    grant_d = d_req & (~bus.i_read | (last_grant_q == GNT_I));
`else
    grant_d = d_req;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      k_q              <= '0;
      line_q           <= '0;
      bus.i_rdata      <= '0;
      bus.i_resp       <= 1'b0;
      bus.d_rdata      <= '0;
      bus.d_resp       <= 1'b0;
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= '0;
      bus.pmem_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q     <= GNT_I;
`endif
    end else begin
      bus.i_resp <= 1'b0;
      bus.d_resp <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            k_q <= '0;
            if (grant_d) begin
              bus.pmem_address <= bus.d_addr & 32'hFFFF_FFE0;
`ifdef ARB_ROUND_ROBIN_EN
              last_grant_q <= GNT_D;
`endif
              if (bus.d_write) begin
                state_q        <= D_WR;
                bus.pmem_write <= 1'b1;
                line_q         <= bus.d_wdata;
                bus.pmem_wdata <= bus.d_wdata[63:0];
              end else begin
                state_q       <= D_RD;
                bus.pmem_read <= 1'b1;
              end
            end else begin
              state_q          <= I_RD;
              bus.pmem_read    <= 1'b1;
              bus.pmem_address <= bus.i_addr & 32'hFFFF_FFE0;
`ifdef ARB_ROUND_ROBIN_EN
              last_grant_q <= GNT_I;
`endif
            end
          end
        end

        I_RD, D_RD: begin
          if (bus.pmem_resp) begin
            line_q[{k_q, 6'd0} +: 64] <= bus.pmem_rdata;
            k_q <= k_next;
            if (k_q == 2'd3) begin
              // Final beat goes straight into the response register alongside the buffer.
              state_q          <= DONE;
              bus.pmem_read    <= 1'b0;
              bus.pmem_address <= '0;
              if (state_q == I_RD) begin
                bus.i_resp  <= 1'b1;
                bus.i_rdata <= {bus.pmem_rdata, line_q[191:0]};
              end else begin
                bus.d_resp  <= 1'b1;
                bus.d_rdata <= {bus.pmem_rdata, line_q[191:0]};
              end
            end
          end
        end

        D_WR: begin
          if (bus.pmem_resp) begin
            k_q <= k_next;
            if (k_q == 2'd3) begin
              state_q          <= DONE;
              bus.pmem_write   <= 1'b0;
              bus.pmem_address <= '0;
              bus.pmem_wdata   <= '0;
              bus.d_resp       <= 1'b1;
            end else begin
              bus.pmem_wdata <= line_q[{k_next, 6'd0} +: 64];
            end
          end
        end

        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Directed self-checking bench for cache_pmem_arbiter; memory beats are driven by hand.
// Conflict-order expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_cache_pmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_pmem_arbiter_if bus ();

  cache_pmem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line returned by the memory model in the arbitration scenarios.
  function automatic logic [255:0] exp_line(input logic [31:0] a);
    return {a, 32'd3, a, 32'd2, a, 32'd1, a, 32'd0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_outs", 256'({bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write}), '0);
    check_val("rst_addr", 256'(bus.pmem_address), '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Called at the negedge just after a grant; ends at the negedge of the DONE cycle.
  task automatic serve(input logic [255:0] rline, input int g1, input int g2, input int g3,
                       input logic wr, input logic [31:0] exp_addr, input logic [255:0] wline);
    int gaps[4];
    logic [1:0] exp_rw;
    gaps   = '{0, g1, g2, g3};
    exp_rw = wr ? 2'b01 : 2'b10;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gaps[b]; g++) begin
        check_val("gap_req", 256'({bus.pmem_read, bus.pmem_write}), 256'(exp_rw));
        check_val("gap_addr", 256'(bus.pmem_address), 256'(exp_addr));
        @(negedge clk);
      end
      check_val("beat_req", 256'({bus.pmem_read, bus.pmem_write}), 256'(exp_rw));
      check_val("beat_addr", 256'(bus.pmem_address), 256'(exp_addr));
      if (wr) check_val("wbeat", 256'(bus.pmem_wdata), 256'(wline[b*64 +: 64]));
      bus.pmem_rdata = rline[b*64 +: 64];
      bus.pmem_resp  = 1'b1;
      @(negedge clk);
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
    end
    check_val("done_drop", 256'({bus.pmem_read, bus.pmem_write}), '0);
  endtask

  // Both caches issue two fills each; a finished requester re-issues after 'lag' cycles.
  task automatic run_pair(input string name, input int lag, input logic [3:0] exp_seq);
    logic [3:0] seq;
    int got, i_left, d_left, i_wait, d_wait, bcnt;
    seq = '0; got = 0; i_left = 2; d_left = 2; i_wait = 0; d_wait = 0; bcnt = 0;
    bus.i_addr = 32'h0000_1000;
    bus.d_addr = 32'h0000_2000;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      @(negedge clk);
      if (bus.i_resp || bus.d_resp)
        check_val("one_resp", 256'(bus.i_resp & bus.d_resp), '0);
      if (bus.d_resp) begin
        seq[got] = 1'b1;
        got++;
        check_val("pair_drdata", bus.d_rdata, exp_line(32'h0000_2000));
        bus.d_read = 1'b0; d_left--; d_wait = lag; bcnt = 0;
      end else if (!bus.d_read && d_left > 0) begin
        if (d_wait == 0) bus.d_read = 1'b1; else d_wait--;
      end
      if (bus.i_resp) begin
        seq[got] = 1'b0;
        got++;
        check_val("pair_irdata", bus.i_rdata, exp_line(32'h0000_1000));
        bus.i_read = 1'b0; i_left--; i_wait = lag; bcnt = 0;
      end else if (!bus.i_read && i_left > 0) begin
        if (i_wait == 0) bus.i_read = 1'b1; else i_wait--;
      end
      if (bus.pmem_read) begin
        bus.pmem_rdata = {bus.pmem_address, 32'(bcnt)};
        bus.pmem_resp  = 1'b1;
        bcnt++;
      end else begin
        bus.pmem_resp  = 1'b0;
      end
    end
    bus.pmem_resp = 1'b0;
    bus.i_read    = 1'b0;
    bus.d_read    = 1'b0;
    check_val("pair_timeout", 256'(got), 256'(4));
    check_val(name, 256'(seq), 256'(exp_seq));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] line_a, wline, line_b;
    rst = 1'b0;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_ctl", 256'({bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write}), '0);
    check_val("reset_irdata", bus.i_rdata, '0);
    check_val("reset_drdata", bus.d_rdata, '0);
    check_val("reset_wdata", 256'(bus.pmem_wdata), '0);
    rst = 1'b1;
    @(negedge clk);
    check_val("idle_quiet", 256'({bus.pmem_read, bus.pmem_write}), '0);

    // I-cache fill, back-to-back beats.
    line_a = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_0064;
    @(negedge clk);
    serve(line_a, 0, 0, 0, 1'b0, 32'h0000_0060, '0);
    check_val("i_resp_c5", 256'({bus.i_resp, bus.d_resp}), 256'(2'b10));
    check_val("i_rdata", bus.i_rdata, line_a);
    bus.i_read = 1'b0;
    @(negedge clk);
    check_val("i_resp_drop", 256'(bus.i_resp), '0);
    check_val("i_rdata_hold", bus.i_rdata, line_a);

    // D-cache writeback.
    wline = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    bus.d_write = 1'b1; bus.d_addr = 32'h8000_0040; bus.d_wdata = wline;
    @(negedge clk);
    serve('0, 0, 0, 0, 1'b1, 32'h8000_0040, wline);
    check_val("d_wr_resp", 256'({bus.i_resp, bus.d_resp}), 256'(2'b01));
    bus.d_write = 1'b0;
    @(negedge clk);
    check_val("d_wr_once", 256'({bus.i_resp, bus.d_resp}), '0);
    check_val("i_rdata_hold2", bus.i_rdata, line_a);

    // Conflicts: immediate re-issue separates the two arbitration policies.
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    run_pair("order_lag0", 0, 4'b0101);
`else
    run_pair("order_lag0", 0, 4'b0011);
`endif
    do_reset();
    run_pair("order_lag1", 1, 4'b0101);

    // Stray beat acknowledges in IDLE must not disturb the next fill.
    bus.pmem_resp = 1'b1; bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) @(negedge clk);
    check_val("idle_resp_ign", 256'({bus.pmem_read, bus.i_resp, bus.d_resp}), '0);
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;

    // Fill with irregular beat spacing.
    line_b = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_5555_AAAA};
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_1234;
    @(negedge clk);
    serve(line_b, 0, 3, 1, 1'b0, 32'h0000_1220, '0);
    check_val("gap_iresp", 256'({bus.i_resp, bus.d_resp}), 256'(2'b10));
    check_val("gap_irdata", bus.i_rdata, line_b);
    bus.i_read = 1'b0;
    @(negedge clk);

    // Reset mid-burst abandons the fill; the held request completes afterwards.
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_0040;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      bus.pmem_rdata = line_a[b*64 +: 64];
      bus.pmem_resp  = 1'b1;
      @(negedge clk);
    end
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    rst = 1'b0;
    #1;
    check_val("mid_rst_ctl", 256'({bus.pmem_read, bus.pmem_write, bus.d_resp}), '0);
    check_val("mid_rst_addr", 256'(bus.pmem_address), '0);
    check_val("mid_rst_drdata", bus.d_rdata, '0);
    @(negedge clk);
    check_val("mid_rst_noresp", 256'(bus.d_resp), '0);
    rst = 1'b1;
    @(negedge clk);
    serve(line_b, 0, 0, 0, 1'b0, 32'h0000_0040, '0);
    check_val("reissue_resp", 256'({bus.i_resp, bus.d_resp}), 256'(2'b01));
    check_val("reissue_drdata", bus.d_rdata, line_b);
    bus.d_read = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
